x_23k640_arb: RTL
=================

# x_23K640_arb

Request arbiter placed in front of the multi-SRAM application port. Shares the single 19-bit request/completion interface between NUM_REQ requesters. Grants are round-robin, and a registered output stage drives the downstream request. A tag FIFO tracks read ownership so each read completion is routed back to the requester that issued it.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TAG_DEPTH, 8, max outstanding reads (power of two, 2..16)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is asynchronous and active-low
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_accept  out  NUM_REQ  per-requester accept (one-hot or zero)
- i_req_rd_n_wr  in  NUM_REQ  per-requester 1=read, 0=write
- i_req_addr  in  NUM_REQ x 19  per-requester byte address
- i_req_wdata  in  NUM_REQ x 8  per-requester write data
- o_cpl_ready  out  NUM_REQ  per-requester read-completion strobe (one-hot or zero)
- o_cpl_rdata  out  8  completion data, shared by all requesters
- o_valid  out  1  downstream request valid
- i_accept  in  1  downstream accept
- o_rd_n_wr  out  1  downstream read/write
- o_addr  out  19  downstream address
- o_wdata  out  8  downstream write data
- i_ready  in  1  downstream read completion strobe
- i_rdata  in  8  downstream read data

## Operation
- Downstream contract:
  - i_ready pulses exactly once per accepted read, in read-acceptance order.
  - Writes produce no completion.
- Output slot:
  - The slot is one register set {o_valid, o_rd_n_wr, o_addr, o_wdata}.
  - The slot is free when o_valid=0 or i_accept=1.
  - o_valid and all o_* fields stay stable until i_accept.
- Eligibility: requester i is eligible when i_req_valid[i]=1 and either it is a write, or it is a read and tag count < TAG_DEPTH.
- Arbitration (combinational):
  - Search starts at rr_ptr and proceeds upward with wrap; the first eligible requester is the winner.
  - o_req_accept[winner]=1 only when the slot is free; that request is loaded into the slot in the same edge.
- rr_ptr update: rr_ptr <= (winner+1) mod NUM_REQ on each accepted grant; otherwise it is unchanged.
- Read grant: the requester index is pushed into the tag FIFO at grant, not at the downstream accept.
- Completion path:
  - i_ready pops the FIFO head h.
  - Next cycle: o_cpl_ready[h]=1 and o_cpl_rdata=i_rdata (registered).
- Push and pop in the same cycle: count is unchanged. The full check uses the pre-edge count, so a read is refused when count=TAG_DEPTH even if a pop happens in the same cycle.
- Spurious completion (i_ready while the FIFO is empty): dropped, no o_cpl_ready pulse, count stays 0.
- Requester side: a requester whose valid drops before accept loses nothing; no request state is held for it.
- Reset mid-operation: the slot, FIFO and rr_ptr are cleared. Outstanding reads are abandoned and their later completions are treated as spurious.

## Timing
- Reset values:
  - o_valid=0, o_rd_n_wr=0, o_addr=0, o_wdata=0
  - o_req_accept=0 while in reset
  - o_cpl_ready=0, o_cpl_rdata=0
  - rr_ptr=0, count=0
- Request latency: accept at edge N; o_valid=1 from cycle N+1.
- Back-to-back throughput: 1 grant/cycle while i_accept is held high.
- Completion latency: i_ready at cycle M gives o_cpl_ready at cycle M+1, 1-cycle pulse.
- o_req_accept is combinational from i_req_valid, i_req_rd_n_wr, i_accept and registered state; no path depends on i_ready.

## Configuration
- X_23K640_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest eligible index wins; rr_ptr is removed.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both modes.

## Structure
- Shared package x_23K640_pkg:
  - ADDR_W=19, DATA_W=8
  - request struct {rd_n_wr, addr, wdata}
  - requester index type
- Sub-module x_23K640_tagfifo:
  - Synchronous FIFO, width clog2(NUM_REQ), depth TAG_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clock/reset scheme as this block.
- Arbiter and output slot stay in x_23K640_arb.

## Test plan
- Single write: req0 write addr 0x12345 data 0xA5, i_accept=1. Expect o_req_accept[0] that cycle; next cycle o_valid=1, o_addr=0x12345, o_wdata=0xA5; no o_cpl_ready.
- Round-robin, all 4 requesters holding reads, i_accept=1:
  - Default build: grant order 0,1,2,3,0.
  - With X_23K640_ARB_FIXED_PRIO_EN: grants stay on 0.
- Backpressure: i_accept=0 for 5 cycles with req1 pending. Expect o_valid and fields stable; no further o_req_accept; grant resumes the cycle i_accept=1.
- Completion routing: reads issued by req2, req0, req3; i_ready with i_rdata 0x11, 0x22, 0x33. Expect o_cpl_ready pulses on 2, 0, 3 with matching data, each one cycle after i_ready.
- Tag full: TAG_DEPTH=8 reads outstanding. Expect a further read refused while a concurrent write from another requester is accepted. One i_ready frees a tag and the read is granted the next cycle.
- Reset and spurious completion: assert i_rst low with 3 reads outstanding. Expect all outputs at reset values; after release, i_ready produces no o_cpl_ready.

Source files
------------

// File: rtl/x_23K640_pkg.sv
// Shared types for the 23K640 request arbiter: request payload, requester index
// and the round-robin pointer helper.
package x_23K640_pkg;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 8;

    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

    typedef struct packed {
        logic              rd_n_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic req_idx_t wrap_inc(input req_idx_t idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : req_idx_t'(int'(idx) + 1);
    endfunction

endpackage

// File: rtl/x_23K640_tagfifo.sv
// Read-ownership tag FIFO: holds the requester index of every outstanding read
// in acceptance order. Push when full and pop when empty are ignored.
module x_23K640_tagfifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of a combinational block is given a default first so no path can infer a latch.
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/x_23k640_arb.sv
// Round-robin request arbiter with registered downstream slot and read-tag routing.
// Define X_23K640_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no rr pointer).
module x_23k640_arb
    import x_23K640_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_accept,
    input  logic [NUM_REQ-1:0]          i_req_rd_n_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]          o_cpl_ready,
    output logic [DATA_W-1:0]           o_cpl_rdata,
    output logic                        o_valid,
    input  logic                        i_accept,
    output logic                        o_rd_n_wr,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [DATA_W-1:0]           o_wdata,
    input  logic                        i_ready,
    input  logic [DATA_W-1:0]           i_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic                 valid_q, valid_d;
    req_t                 slot_q, slot_d;
    logic [NUM_REQ-1:0]   cpl_ready_q, cpl_ready_d;
    logic [DATA_W-1:0]    cpl_rdata_q, cpl_rdata_d;

    req_t                 req_vec [NUM_REQ];
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   accept;
    logic                 slot_free;
    logic                 found;
    logic                 grant;
    req_idx_t             win;
    req_t                 win_req;
    int                   search_base;
    int                   search_idx;

    logic                 tag_push, tag_pop, tag_full, tag_empty;
    logic [IDX_W-1:0]     tag_din, tag_dout;
    logic [CNT_W-1:0]     tag_count;

`ifndef X_23K640_ARB_FIXED_PRIO_EN
    req_idx_t             rr_ptr_q, rr_ptr_d;
`endif

    assign slot_free = !valid_q || i_accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i].rd_n_wr = i_req_rd_n_wr[i];
            req_vec[i].addr    = i_req_addr[i*ADDR_W +: ADDR_W];
            req_vec[i].wdata   = i_req_wdata[i*DATA_W +: DATA_W];
            eligible[i]        = i_req_valid[i] &&
                                 (!i_req_rd_n_wr[i] || (tag_count < CNT_W'(TAG_DEPTH)));
        end
    end

    // Search from the base index upward with wrap; first eligible requester wins.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        search_idx = 0;
`ifdef X_23K640_ARB_FIXED_PRIO_EN
        search_base = 0;
`else
        search_base = int'(rr_ptr_q);
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = search_base + k;
            if (search_idx >= NUM_REQ) search_idx = search_idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == search_idx) && eligible[i]) begin
                    found = 1'b1;
                    win   = req_idx_t'(i);
                end
            end
        end
    end

    // Gating with i_rst keeps the accept strobe low while async reset holds state.
    always_comb begin
        grant   = found && slot_free && i_rst;
        win_req = req_vec[0];
        for (int i = 0; i < NUM_REQ; i++) begin
            accept[i] = grant && (i == int'(win));
            if (i == int'(win)) win_req = req_vec[i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (grant) begin
            valid_d = 1'b1;
            slot_d  = win_req;
        end else if (i_accept) begin
            valid_d = 1'b0;
        end
    end

`ifndef X_23K640_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = wrap_inc(win, NUM_REQ);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Tag is taken at grant time, so the slot may still be waiting downstream.
    assign tag_push = grant && win_req.rd_n_wr && !tag_full;
    assign tag_din  = IDX_W'(win);
    assign tag_pop  = i_ready && !tag_empty;

    x_23K640_tagfifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tagfifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (tag_din),
        .dout  (tag_dout),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_comb begin
        cpl_ready_d = '0;
        cpl_rdata_d = cpl_rdata_q;
        if (tag_pop) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cpl_ready_d[i] = (i == int'(tag_dout));
            end
            cpl_rdata_d = i_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_q     <= 1'b0;
            slot_q      <= '0;
            cpl_ready_q <= '0;
            cpl_rdata_q <= '0;
        end else begin
            valid_q     <= valid_d;
            slot_q      <= slot_d;
            cpl_ready_q <= cpl_ready_d;
            cpl_rdata_q <= cpl_rdata_d;
        end
    end

    assign o_req_accept = accept;
    assign o_valid      = valid_q;
    assign o_rd_n_wr    = slot_q.rd_n_wr;
    assign o_addr       = slot_q.addr;
    assign o_wdata      = slot_q.wdata;
    assign o_cpl_ready  = cpl_ready_q;
    assign o_cpl_rdata  = cpl_rdata_q;

endmodule
